ram128m: RTL and testbench



---
 rtl/ram128m.sv | 103 ++++++++++
 tb/tb_ram128m.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram128m.sv
// Dual-read, single-write synchronous RAM of 2^ADDR_WIDTH words, organised as 2^BANK_ADDR_WIDTH-word banks.
// Each bank registers its own read word per port; a registered bank select then picks the port output.
module ram128m #(
    parameter int unsigned ADDR_WIDTH      = 27,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned BANK_ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out_a,
    output logic [DATA_WIDTH-1:0] d_out_b
);

    localparam int unsigned SEL_WIDTH  = ADDR_WIDTH - BANK_ADDR_WIDTH;
    localparam int unsigned NUM_BANKS  = 1 << SEL_WIDTH;
    localparam int unsigned BANK_DEPTH = 1 << BANK_ADDR_WIDTH;

    // Address split into bank select and in-bank offset
    logic [SEL_WIDTH-1:0]       wr_bank_c;
    logic [BANK_ADDR_WIDTH-1:0] wr_off_c;
    logic [SEL_WIDTH-1:0]       rd_bank_a_c;
    logic [BANK_ADDR_WIDTH-1:0] rd_off_a_c;
    logic [SEL_WIDTH-1:0]       rd_bank_b_c;
    logic [BANK_ADDR_WIDTH-1:0] rd_off_b_c;

    assign wr_bank_c   = wr_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    assign wr_off_c    = wr_addr[BANK_ADDR_WIDTH-1:0];
    assign rd_bank_a_c = rd_addr_a[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    assign rd_off_a_c  = rd_addr_a[BANK_ADDR_WIDTH-1:0];
    assign rd_bank_b_c = rd_addr_b[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    assign rd_off_b_c  = rd_addr_b[BANK_ADDR_WIDTH-1:0];

    logic [NUM_BANKS-1:0] wr_onehot_c;

    // One-hot bank write enable
    always_comb begin
        wr_onehot_c = '0;
        if (wr) begin
            wr_onehot_c[wr_bank_c] = 1'b1;
        end
    end

    // Storage: deliberately unreset so contents survive reset
    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

    always_ff @(posedge clk) begin
        if (reset && wr_onehot_c[wr_bank_c]) begin
            mem[wr_bank_c][wr_off_c] <= d_in;
        end
    end

    logic [DATA_WIDTH-1:0] bank_rd_a_d [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rd_a_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rd_b_d [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rd_b_q [NUM_BANKS];
    logic [SEL_WIDTH-1:0]  bank_sel_a_d;
    logic [SEL_WIDTH-1:0]  bank_sel_a_q;
    logic [SEL_WIDTH-1:0]  bank_sel_b_d;
    logic [SEL_WIDTH-1:0]  bank_sel_b_q;

    // Per-bank read words with write-first bypass when this bank is written at the same offset
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_rd_a_d[b] = mem[b][rd_off_a_c];
            bank_rd_b_d[b] = mem[b][rd_off_b_c];
            if (wr_onehot_c[SEL_WIDTH'(b)] && (wr_off_c == rd_off_a_c)) begin
                bank_rd_a_d[b] = d_in;
            end
            if (wr_onehot_c[SEL_WIDTH'(b)] && (wr_off_c == rd_off_b_c)) begin
                bank_rd_b_d[b] = d_in;
            end
        end
    end

    always_comb begin
        bank_sel_a_d = rd_bank_a_c;
        bank_sel_b_d = rd_bank_b_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_rd_a_q  <= '{default: '0};
            bank_rd_b_q  <= '{default: '0};
            bank_sel_a_q <= '0;
            bank_sel_b_q <= '0;
        end else begin
            bank_rd_a_q  <= bank_rd_a_d;
            bank_rd_b_q  <= bank_rd_b_d;
            bank_sel_a_q <= bank_sel_a_d;
            bank_sel_b_q <= bank_sel_b_d;
        end
    end

    // Per-port output mux over registered bank words
    assign d_out_a = bank_rd_a_q[bank_sel_a_q];
    assign d_out_b = bank_rd_b_q[bank_sel_b_q];

endmodule

// File: tb/tb_ram128m.sv
// Directed self-checking bench for ram128m: reset, basic access, bank boundaries,
// same-edge write-first, reset mid-run and back-to-back streaming.
module tb_ram128m;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [26:0] wr_addr;
    logic [26:0] rd_addr_a;
    logic [26:0] rd_addr_b;
    logic [15:0] d_in;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;

    int n_checks = 0;
    int n_pass   = 0;

    ram128m dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic write_word(input logic [26:0] addr, input logic [15:0] data);
        wr      = 1'b1;
        wr_addr = addr;
        d_in    = data;
        tick();
        wr      = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        wr        = 1'b0;
        wr_addr   = 27'h0;
        rd_addr_a = 27'h1234567;
        rd_addr_b = 27'h7654321;
        d_in      = 16'h0;

        tick();
        tick();
        check("reset_a", d_out_a, 16'h0000);
        check("reset_b", d_out_b, 16'h0000);

        reset     = 1'b1;
        rd_addr_a = 27'h0003039;
        rd_addr_b = 27'h7FFFFFF;
        tick();
        check("unwritten_a", d_out_a, 16'h0000);
        check("unwritten_b", d_out_b, 16'h0000);

        write_word(27'd1, 16'hABCD);
        write_word(27'd2, 16'h1234);
        rd_addr_a = 27'd1;
        rd_addr_b = 27'd2;
        tick();
        check("basic_a", d_out_a, 16'hABCD);
        check("basic_b", d_out_b, 16'h1234);

        write_word(27'h000FFFF, 16'h1111);
        write_word(27'h0010000, 16'h2222);
        write_word(27'h7FFFFFF, 16'h3333);
        rd_addr_a = 27'h000FFFF;
        rd_addr_b = 27'h0010000;
        tick();
        check("bnd_a_ffff", d_out_a, 16'h1111);
        check("bnd_b_10000", d_out_b, 16'h2222);
        rd_addr_a = 27'h7FFFFFF;
        rd_addr_b = 27'h000FFFF;
        tick();
        check("bnd_a_top", d_out_a, 16'h3333);
        check("bnd_b_ffff", d_out_b, 16'h1111);
        rd_addr_a = 27'h0010000;
        rd_addr_b = 27'h7FFFFFF;
        tick();
        check("bnd_a_10000", d_out_a, 16'h2222);
        check("bnd_b_top", d_out_b, 16'h3333);
        rd_addr_a = 27'h0000000;
        rd_addr_b = 27'h001FFFF;
        tick();
        check("alias_a_0", d_out_a, 16'h0000);
        check("alias_b_1ffff", d_out_b, 16'h0000);
        rd_addr_a = 27'h7FF0000;
        rd_addr_b = 27'h47FFFFF;
        tick();
        check("alias_a_7ff0000", d_out_a, 16'h0000);
        check("alias_b_47fffff", d_out_b, 16'h0000);

        // Same-edge collision on both ports
        rd_addr_a = 27'd5;
        rd_addr_b = 27'd5;
        write_word(27'd5, 16'hBEEF);
        check("wf_a", d_out_a, 16'hBEEF);
        check("wf_b", d_out_b, 16'hBEEF);
        tick();
        check("wf_hold_a", d_out_a, 16'hBEEF);
        // Same offset, different bank must not bypass
        write_word(27'h0020005, 16'h7777);
        check("wf_other_bank_a", d_out_a, 16'hBEEF);
        rd_addr_b = 27'h0020005;
        tick();
        check("other_bank_b", d_out_b, 16'h7777);

        write_word(27'd100, 16'h5A5A);
        rd_addr_a = 27'd100;
        rd_addr_b = 27'd100;
        tick();
        check("pre_rst_a", d_out_a, 16'h5A5A);
        check("pre_rst_b", d_out_b, 16'h5A5A);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_a", d_out_a, 16'h0000);
        check("async_rst_b", d_out_b, 16'h0000);
        wr      = 1'b1;
        wr_addr = 27'd100;
        d_in    = 16'hFFFF;
        tick();
        check("rst_hold_a", d_out_a, 16'h0000);
        check("rst_hold_b", d_out_b, 16'h0000);
        wr = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check("post_rst_a", d_out_a, 16'h5A5A);
        check("post_rst_b", d_out_b, 16'h5A5A);

        // Stream 16 writes while A trails one address behind
        rd_addr_b = 27'h3000000;
        for (int i = 0; i < 16; i++) begin
            wr        = 1'b1;
            wr_addr   = 27'h200 + 27'(i);
            d_in      = 16'hC000 + 16'(i);
            rd_addr_a = (i == 0) ? 27'h3000001 : 27'h200 + 27'(i - 1);
            tick();
            if (i == 0) check("b2b_a0", d_out_a, 16'h0000);
            else        check("b2b_a", d_out_a, 16'hC000 + 16'(i - 1));
            check("b2b_b", d_out_b, 16'h0000);
        end
        wr        = 1'b0;
        rd_addr_a = 27'h20F;
        tick();
        check("b2b_last_a", d_out_a, 16'hC00F);
        check("b2b_last_b", d_out_b, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
